// File: rtl/gbc_catc.sv
// -----------------------------------------------------------------------------
// gbc_catc -- clock-enable tick scheduler for the Game Boy Color core.
//
// A fractional phase accumulator turns the system clock into the machine tick
// rate (TickRate, or 2*TickRate in double-speed mode). While the downstream
// blocks stall, ticks that could not be issued are banked as debt and replayed
// back-to-back once the stall clears.
//
// Optional feature macro: GBC_CATC_CATCHUP_EN
//   defined     : debt bank holds up to MaxDebt ticks.
//   not defined : only one tick is buffered across a stall (effective
//                 MaxDebt = 1); the debt port then only reads 0 or 1.
//
// Ports:
//   clk           system clock, the only clock
//   rst           synchronous active-high reset
//   stall         downstream not ready; suppresses ticks combinationally
//   double_speed  CGB double-speed mode; doubles the tick rate
//   clk_en_out    one-cycle-wide core clock enable per tick
//   overflow      sticky: a tick was dropped because debt was saturated
//   debt          number of currently banked ticks
//   tick_count    issued ticks, wraps modulo 2^16
// -----------------------------------------------------------------------------
module gbc_catc #(
    parameter int CoreClock = 200000000,
    parameter int TickRate  = 4194304,
    parameter int MaxDebt   = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           double_speed,
    output logic                           clk_en_out,
    output logic                           overflow,
    output logic [$clog2(MaxDebt+1)-1:0]   debt,
    output logic [15:0]                    tick_count
);

    localparam int AW = $clog2(CoreClock) + 1;
    localparam int DW = $clog2(MaxDebt + 1);

`ifdef GBC_CATC_CATCHUP_EN
    localparam int EFF_MAX = MaxDebt;
`else
    localparam int EFF_MAX = 1;
`endif

    localparam logic [AW:0]   CORE_W   = (AW+1)'(CoreClock);
    localparam logic [AW-1:0] INC_N    = AW'(TickRate);
    localparam logic [AW-1:0] INC_D    = AW'(2 * TickRate);
    localparam logic [DW-1:0] DEBT_MAX = DW'(EFF_MAX);

    // Parameter sanity: the doubled tick must stay below the system clock so
    // that at most one raw tick can occur per cycle.
    if ((2 * TickRate >= CoreClock) || (MaxDebt < 1)) begin : g_param_err
        $error("gbc_catc: need 2*TickRate < CoreClock and MaxDebt >= 1");
    end

    logic [AW-1:0] acc_r;
    logic [DW-1:0] debt_r;
    logic          overflow_r;
    logic [15:0]   tick_count_r;

    logic [AW-1:0] inc_s;
    logic [AW:0]   sum_s;
    logic [AW-1:0] acc_next_s;
    logic          raw_s;
    logic          issue_s;
    logic [DW-1:0] debt_next_s;
    logic          overflow_next_s;
    logic [15:0]   tick_count_next_s;

    // Phase accumulator: add the rate increment, wrap at CoreClock and flag a raw tick.
    always_comb begin
        inc_s      = INC_N;
        sum_s      = {(AW+1){1'b0}};
        acc_next_s = acc_r;
        raw_s      = 1'b0;
        if (double_speed) begin
            inc_s = INC_D;
        end else begin
            inc_s = INC_N;
        end
        sum_s = {1'b0, acc_r} + {1'b0, inc_s};
        if (sum_s >= CORE_W) begin
            raw_s      = 1'b1;
            acc_next_s = AW'(sum_s - CORE_W);
        end else begin
            raw_s      = 1'b0;
            acc_next_s = sum_s[AW-1:0];
        end
    end

    // Issue is combinational on the live stall so the core sees the enable in
    // the same cycle the stall drops; it is forced low while reset is held.
    assign issue_s = ~rst & ~stall & (debt_r != {DW{1'b0}});

    // Debt bank: a raw tick that cannot be issued is banked (or dropped when
    // full); an issue without a new raw tick pays one tick back.
    always_comb begin
        debt_next_s     = debt_r;
        overflow_next_s = overflow_r;
        case ({raw_s, issue_s})
            2'b10: begin
                if (debt_r < DEBT_MAX) begin
                    debt_next_s = debt_r + DW'(1'b1);
                end else begin
                    overflow_next_s = 1'b1;
                end
            end
            2'b01: begin
                debt_next_s = debt_r - DW'(1'b1);
            end
            default: begin
                debt_next_s = debt_r;
            end
        endcase
        tick_count_next_s = tick_count_r + {15'd0, issue_s};
    end

    // State registers with synchronous reset; reset discards any banked debt.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= {AW{1'b0}};
            debt_r       <= {DW{1'b0}};
            overflow_r   <= 1'b0;
            tick_count_r <= 16'd0;
        end else begin
            acc_r        <= acc_next_s;
            debt_r       <= debt_next_s;
            overflow_r   <= overflow_next_s;
            tick_count_r <= tick_count_next_s;
        end
    end

    assign clk_en_out = issue_s;
    assign overflow   = overflow_r;
    assign debt       = debt_r;
    assign tick_count = tick_count_r;

endmodule

// File: tb/tb_gbc_catc.sv
// -----------------------------------------------------------------------------
// tb_gbc_catc -- self-checking bench for gbc_catc (CoreClock=16, TickRate=4,
// MaxDebt=3). The reference model tracks the total elapsed phase as an
// unbounded integer: a raw tick happens whenever floor(phase/CoreClock)
// advances. Debt, overflow and tick count follow from the bank rules.
// -----------------------------------------------------------------------------
module tb_gbc_catc;

    localparam int CORE = 16;
    localparam int TR   = 4;
    localparam int MAXD = 3;
`ifdef GBC_CATC_CATCHUP_EN
    localparam int EFF_MAX = MAXD;
`else
    localparam int EFF_MAX = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        double_speed = 1'b0;
    logic        clk_en_out;
    logic        overflow;
    logic [1:0]  debt;
    logic [15:0] tick_count;

    gbc_catc #(.CoreClock(CORE), .TickRate(TR), .MaxDebt(MAXD)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .double_speed (double_speed),
        .clk_en_out   (clk_en_out),
        .overflow     (overflow),
        .debt         (debt),
        .tick_count   (tick_count)
    );

    always #5 clk = ~clk;

    // reference model state
    longint m_phase = 0;
    int     m_debt  = 0;
    bit     m_ovf   = 1'b0;
    int     m_cnt   = 0;

    // observed / expected for the current cycle
    logic        o_en, o_ovf, e_en, e_ovf;
    logic [1:0]  o_debt, e_debt;
    logic [15:0] o_cnt, e_cnt;

    int total  = 0;
    int passed = 0;

    function automatic string obs_str();
        return $sformatf("got en=%b debt=%0d ovf=%b cnt=%0d, want en=%b debt=%0d ovf=%b cnt=%0d",
                         o_en, o_debt, o_ovf, o_cnt, e_en, e_debt, e_ovf, e_cnt);
    endfunction

    // One clock cycle: drive at the falling edge, sample, then advance the model.
    task automatic step(input logic s, input logic d, input logic r);
        longint inc;
        bit     raw;
        stall        = s;
        double_speed = d;
        rst          = r;
        #1;
        o_en   = clk_en_out;
        o_debt = debt;
        o_ovf  = overflow;
        o_cnt  = tick_count;
        e_en   = !r && !s && (m_debt > 0);
        e_debt = 2'(m_debt);
        e_ovf  = m_ovf;
        e_cnt  = 16'(m_cnt);
        if (r) begin
            m_phase = 0;
            m_debt  = 0;
            m_ovf   = 1'b0;
            m_cnt   = 0;
        end else begin
            inc = d ? 2 * TR : TR;
            raw = ((m_phase + inc) / CORE) > (m_phase / CORE);
            m_phase = m_phase + inc;
            if (raw && !e_en) begin
                if (m_debt < EFF_MAX) m_debt = m_debt + 1;
                else m_ovf = 1'b1;
            end else if (!raw && e_en) begin
                m_debt = m_debt - 1;
            end
            if (e_en) m_cnt = (m_cnt + 1) % 65536;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL reset cyc %0d: %s", i, obs_str());
            else passed++;
        end
    endtask

    task automatic test_free_run();
        int first_pulse = 0;
        int max_debt = 0;
        for (int i = 1; i <= 404; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL free_run cyc %0d: %s", i, obs_str());
            else passed++;
            if (o_en === 1'b1 && first_pulse == 0) first_pulse = i;
            if (int'(o_debt) > max_debt) max_debt = int'(o_debt);
        end
        total++;
        if (first_pulse !== 5) $display("FAIL first_pulse: got cycle %0d, want 5", first_pulse);
        else passed++;
        total++;
        if (tick_count !== 16'd100) $display("FAIL free_run_count: got %0d, want 100", tick_count);
        else passed++;
        total++;
        if (max_debt > 1) $display("FAIL free_run_debt: got max %0d, want <= 1", max_debt);
        else passed++;
    endtask

    task automatic test_double_speed();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL double_speed cyc %0d: %s", i, obs_str());
            else passed++;
            if (i >= 20 && o_en === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 20) $display("FAIL double_rate: got %0d pulses in 40 cycles, want 20", pulses);
        else passed++;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL back_to_normal cyc %0d: %s", i, obs_str());
            else passed++;
            if (i >= 20 && o_en === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 10) $display("FAIL normal_rate: got %0d pulses in 40 cycles, want 10", pulses);
        else passed++;
    endtask

    task automatic test_short_stall();
        int lo, hi;
        lo = (EFF_MAX < 2) ? EFF_MAX : 2;
        hi = (EFF_MAX < 3) ? EFF_MAX : 3;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL short_stall cyc %0d: %s", i, obs_str());
            else passed++;
        end
        total++;
        if (int'(debt) < lo || int'(debt) > hi)
            $display("FAIL short_stall_debt: got %0d, want %0d..%0d", debt, lo, hi);
        else passed++;
        total++;
        if (overflow !== 1'(EFF_MAX < 2))
            $display("FAIL short_stall_ovf: got %b, want %b", overflow, 1'(EFF_MAX < 2));
        else passed++;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL short_release cyc %0d: %s", i, obs_str());
            else passed++;
        end
    endtask

    task automatic test_long_stall();
        int run;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL long_stall cyc %0d: %s", i, obs_str());
            else passed++;
        end
        total++;
        if (debt !== 2'(EFF_MAX) || overflow !== 1'b1)
            $display("FAIL long_stall_sat: got debt=%0d ovf=%b, want debt=%0d ovf=1", debt, overflow, EFF_MAX);
        else passed++;
        run = 0;
        o_en = 1'b1;
        while (o_en === 1'b1 && run < 20) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL long_release cyc %0d: %s", run, obs_str());
            else passed++;
            if (o_en === 1'b1) run++;
        end
        total++;
        if (run < EFF_MAX || run > EFF_MAX + 1)
            $display("FAIL replay_burst: got %0d back-to-back, want %0d..%0d", run, EFF_MAX, EFF_MAX + 1);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL long_steady cyc %0d: %s", i, obs_str());
            else passed++;
        end
    endtask

    task automatic test_reset_mid_debt();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        total++;
        if (debt !== 2'd0 || overflow !== 1'b0 || tick_count !== 16'd0)
            $display("FAIL reset_mid_debt: got debt=%0d ovf=%b cnt=%0d, want 0 0 0", debt, overflow, tick_count);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (o_en !== 1'b0) $display("FAIL post_reset_quiet cyc %0d: got en=%b, want 0", i, o_en);
            else passed++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL post_reset cyc %0d: %s", i, obs_str());
            else passed++;
        end
    endtask

    task automatic test_random();
        logic d;
        d = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 5) d = ~d;
            step(1'($urandom_range(0, 99) < 30), d, 1'($urandom_range(0, 199) == 0));
            total++;
            if ({o_en, o_debt, o_ovf, o_cnt} !== {e_en, e_debt, e_ovf, e_cnt})
                $display("FAIL random cyc %0d: %s", i, obs_str());
            else passed++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_free_run();
        test_double_speed();
        test_short_stall();
        test_long_stall();
        test_reset_mid_debt();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
